// File: rtl/regfile_write_arbiter.sv
// Write-port sequencer for the 32x32 register file: zero-fills every register after
// reset/clear, then arbitrates writeback (A) against long-latency results (B).
// Optional: define RF_ARB_ROUND_ROBIN_EN for round-robin arbitration instead of fixed A priority.
module regfile_write_arbiter #(
  parameter int NUM_REGS     = 32,
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic              init_busy,
  output logic [15:0]       conflict_cnt
);

  // state | meaning
  // INIT  | zero-fill walk, one register per cycle, requesters stalled
  // RUN   | arbitrate A/B onto the write port
  typedef enum logic {INIT, RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  state_t            stateQ, stateD;
  logic [ADDR_W-1:0] clrCnt;
  logic              grantA, grantB;

`ifdef RF_ARB_ROUND_ROBIN_EN
  logic lastGrantB;
  assign grantB = b_valid && (!a_valid || !lastGrantB);
`else
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  logic [STARVE_W-1:0] starve;
  assign grantB = b_valid && (!a_valid || (starve == STARVE_W'(STARVE_LIMIT)));
`endif
  assign grantA = a_valid && !grantB;

  assign init_busy = (stateQ == INIT);

  always_comb begin
    stateD  = stateQ;
    a_ready = 1'b0;
    b_ready = 1'b0;
    case (stateQ)
      INIT: begin
        if (clrCnt == LAST_REG) stateD = RUN;
      end
      RUN: begin
        if (clear_req) begin
          stateD = INIT;
        end else begin
          a_ready = grantA;
          b_ready = grantB;
        end
      end
      default: stateD = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ        <= INIT;
      clrCnt        <= '0;
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
      conflict_cnt  <= '0;
`ifdef RF_ARB_ROUND_ROBIN_EN
      lastGrantB    <= 1'b1;
`else
      starve        <= '0;
`endif
    end else begin
      stateQ <= stateD;
      if (stateQ == INIT) begin
        RegWrite      <= 1'b1;
        WriteRegister <= clrCnt;
        WriteData     <= '0;
        clrCnt        <= (clrCnt == LAST_REG) ? '0 : clrCnt + 1'b1;
      end else begin
        if (a_valid && b_valid && (conflict_cnt != 16'hFFFF))
          conflict_cnt <= conflict_cnt + 16'd1;
        // Register 0 is hard-wired zero: accept the request but suppress the write.
        if (clear_req) begin
          RegWrite <= 1'b0;
          clrCnt   <= '0;
        end else if (a_ready) begin
          RegWrite      <= (a_reg != '0);
          WriteRegister <= a_reg;
          WriteData     <= a_data;
        end else if (b_ready) begin
          RegWrite      <= (b_reg != '0);
          WriteRegister <= b_reg;
          WriteData     <= b_data;
        end else begin
          RegWrite <= 1'b0;
        end
`ifdef RF_ARB_ROUND_ROBIN_EN
        if (a_ready)      lastGrantB <= 1'b0;
        else if (b_ready) lastGrantB <= 1'b1;
`else
        if (clear_req || b_ready || !b_valid) starve <= '0;
        else if (a_ready)                     starve <= starve + 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a cycle-level reference model predicts readys,
// conflict count and the ordered list of register-file writes; a monitor checks each write.
module tb_regfile_write_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear_req = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [4:0]  a_reg = '0, b_reg = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready, RegWrite, init_busy;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [15:0] conflict_cnt;

  regfile_write_arbiter dut (
    .clk(clk), .reset(reset), .clear_req(clear_req),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .init_busy(init_busy), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [4:0] r; logic [31:0] d; } wr_t;
  wr_t expQ[$];
  int  checks = 0, errors = 0;

  // reference model state
  int initLeft = 32;
  int bLosses  = 0;
  bit lastWasB = 1'b1;
  int confModel = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (RegWrite !== 1'b0) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got reg %0d data %0h expected no write at %0t",
                 WriteRegister, WriteData, $time);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        chk("write_reg", 64'(WriteRegister), 64'(e.r));
        chk("write_data", 64'(WriteData), 64'(e.d));
      end
    end
  end

  // One clock cycle: drive at negedge, check readys against the model, predict the edge.
  task automatic cycle(input bit aV, input logic [4:0] aR, input logic [31:0] aD,
                       input bit bV, input logic [4:0] bR, input logic [31:0] bD,
                       input bit clr, output bit aAcc, output bit bAcc, output int grant);
    bit eA, eB;
    @(negedge clk);
    reset = 1'b1;
    a_valid = aV; a_reg = aR; a_data = aD;
    b_valid = bV; b_reg = bR; b_data = bD;
    clear_req = clr;
    #1;
    chk("init_busy", 64'(init_busy), 64'(initLeft > 0));
    chk("conflict_cnt", 64'(conflict_cnt), 64'(confModel));
    eA = 1'b0; eB = 1'b0;
    if (initLeft > 0) begin
      expQ.push_back('{r: 5'(32 - initLeft), d: 32'h0});
      initLeft--;
    end else begin
      if (aV && bV && confModel < 65535) confModel++;
      if (clr) begin
        initLeft = 32;
        bLosses  = 0;
      end else if (aV && bV) begin
`ifdef RF_ARB_ROUND_ROBIN_EN
        if (lastWasB) eA = 1'b1; else eB = 1'b1;
`else
        if (bLosses == 4) begin eB = 1'b1; bLosses = 0; end
        else begin eA = 1'b1; bLosses++; end
`endif
      end else begin
        eA = aV; eB = bV;
        bLosses = 0;
      end
      if (eA) lastWasB = 1'b0;
      if (eB) lastWasB = 1'b1;
      if (eA && aR != 0) expQ.push_back('{r: aR, d: aD});
      if (eB && bR != 0) expQ.push_back('{r: bR, d: bD});
    end
    chk("a_ready", 64'(a_ready), 64'(eA));
    chk("b_ready", 64'(b_ready), 64'(eB));
    aAcc = eA; bAcc = eB;
    grant = eA ? 1 : (eB ? 2 : 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; clear_req = 1'b0;
    #1;
    chk("rst_regwrite", 64'(RegWrite), 64'h0);
    chk("rst_wreg", 64'(WriteRegister), 64'h0);
    chk("rst_wdata", 64'(WriteData), 64'h0);
    chk("rst_conflict", 64'(conflict_cnt), 64'h0);
    chk("rst_init_busy", 64'(init_busy), 64'h1);
    chk("rst_readys", 64'({a_ready, b_ready}), 64'h0);
    chk("rst_pending_writes", 64'(expQ.size()), 64'h0);
    expQ.delete();
    initLeft = 32; bLosses = 0; lastWasB = 1'b1; confModel = 0;
  endtask

  initial begin
    bit aA, bA, aP, bP, clr;
    int g, startConf;
    int grants[10];
    int fixedSeq[10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
    logic [4:0]  aR, bR;
    logic [31:0] aD, bD;

    // zero-fill after reset release, then the first RUN cycle
    doReset();
    repeat (33) cycle(0, 0, 0, 0, 0, 0, 0, aA, bA, g);

    // single A request, accepted same cycle
    cycle(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, aA, bA, g);
    chk("single_a_accept", 64'(aA), 64'h1);
    cycle(0, 0, 0, 0, 0, 0, 0, aA, bA, g);

    // continuous contention on the same register
    startConf = confModel;
    for (int i = 0; i < 10; i++) begin
      cycle(1, 5'd7, 32'hA000_0000 + 32'(i), 1, 5'd7, 32'hB000_0000 + 32'(i), 0, aA, bA, g);
      grants[i] = g;
    end
    cycle(0, 0, 0, 0, 0, 0, 0, aA, bA, g);
    chk("contention_conflicts", 64'(conflict_cnt), 64'(startConf + 10));
    for (int i = 0; i < 10; i++) begin
`ifdef RF_ARB_ROUND_ROBIN_EN
      if (i > 0) chk("rr_alternate", 64'(grants[i] != grants[i-1]), 64'h1);
`else
      chk("fixed_grant_seq", 64'(grants[i]), 64'(fixedSeq[i]));
`endif
    end

    // register 0 accepted, no write
    cycle(0, 0, 0, 1, 5'd0, 32'h1, 0, aA, bA, g);
    chk("reg0_accept", 64'(bA), 64'h1);
    cycle(0, 0, 0, 0, 0, 0, 0, aA, bA, g);

    // soft clear with requests pending, then reset at clr_cnt=12
    cycle(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 1, aA, bA, g);
    repeat (12) cycle(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0, aA, bA, g);
    doReset();

    // randomized traffic with requests held until accepted and occasional clears
    aP = 0; bP = 0; aR = '0; bR = '0; aD = '0; bD = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!aP && $urandom_range(0, 3) != 0) begin aP = 1; aR = 5'($urandom); aD = $urandom; end
      if (!bP && $urandom_range(0, 2) != 0) begin bP = 1; bR = 5'($urandom); bD = $urandom; end
      clr = ($urandom_range(0, 199) == 0);
      cycle(aP, aR, aD, bP, bR, bD, clr, aA, bA, g);
      if (aA) aP = 0;
      if (bA) bP = 0;
    end
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, aA, bA, g);
    @(negedge clk);
    chk("final_pending_writes", 64'(expQ.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
